// File: rtl/switch_input_port_pkg.sv
// Shared definitions for the switch input port: bus address, default debounce
// window and debounce FSM state encoding.
package switch_input_port_pkg;

    localparam logic [31:0] SW_PORT_ADDR            = 32'h0000_1000;
    localparam int          DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int          DATA_WORD_W             = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } dbnc_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (switches, buttons).
// Output is stable two clk edges after the raw input settles.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/switch_input_port.sv
// Slide-switch input port: synchronizes and debounces sw_i, exposes the stable
// value as a 32-bit read word, and keeps sticky change/rise flags cleared by rd_i.
module switch_input_port
    import switch_input_port_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [WIDTH-1:0]       sw_i,
    input  logic                   rd_i,
    output logic [DATA_WORD_W-1:0] data_o,
    output logic                   event_o,
    output logic [WIDTH-1:0]       rise_o,
    output logic                   busy_o
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] w_sync;

    dbnc_state_e      r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cand,  w_cand_nxt;
    logic [CW-1:0]    r_cnt,   w_cnt_nxt;
    logic [WIDTH-1:0] r_db,    w_db_nxt;
    logic             r_event, w_event_nxt;
    logic [WIDTH-1:0] r_rise,  w_rise_nxt;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (sw_i),
        .q_o  (w_sync)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_db    <= '0;
            r_event <= 1'b0;
            r_rise  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= w_db_nxt;
            r_event <= w_event_nxt;
            r_rise  <= w_rise_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_db_nxt    = r_db;
        case (r_state)
            ST_IDLE: begin
                if (w_sync != r_db) begin
                    w_state_nxt = ST_COUNT;
                    w_cand_nxt  = w_sync;
                    w_cnt_nxt   = '0;
                end
            end
            ST_COUNT: begin
                // A glitch that returns to the committed value abandons the window.
                if (w_sync == r_db) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sync != r_cand) begin
                    w_cand_nxt = w_sync;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_db_nxt    = r_cand;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Read clears first, then a same-cycle commit sets, so no event is lost.
        w_event_nxt = rd_i ? 1'b0 : r_event;
        w_rise_nxt  = rd_i ? '0 : r_rise;
        if (w_db_nxt != r_db) begin
            w_event_nxt = 1'b1;
            w_rise_nxt  = w_rise_nxt | (w_db_nxt & ~r_db);
        end
    end

    assign data_o  = DATA_WORD_W'(r_db);
    assign event_o = r_event;
    assign rise_o  = r_rise;
    assign busy_o  = (r_state == ST_COUNT);

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with a 4-cycle debounce window and 16 switches.
module tb_switch_input_port;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] sw_i;
    logic        rd_i;
    logic [31:0] data_o;
    logic        event_o;
    logic [15:0] rise_o;
    logic        busy_o;

    int n_pass  = 0;
    int n_total = 0;

    switch_input_port #(
        .WIDTH           (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sw_i    (sw_i),
        .rd_i    (rd_i),
        .data_o  (data_o),
        .event_o (event_o),
        .rise_o  (rise_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Hold reset for two edges, release just after an edge so the next edge is edge 1.
    task automatic do_reset(input logic [15:0] sw);
        rstn = 1'b0;
        sw_i = sw;
        tick(2);
        rstn = 1'b1;
    endtask

    task automatic read_pulse();
        rd_i = 1'b1;
        tick(1);
        rd_i = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        sw_i = 16'hFFFF;
        rd_i = 1'b0;

        // 1. Reset with all switches up, then debounce them in.
        tick(2);
        chk("rst_data",  data_o, 32'h0);
        chk("rst_event", 32'(event_o), 32'h0);
        chk("rst_rise",  32'(rise_o), 32'h0);
        chk("rst_busy",  32'(busy_o), 32'h0);
        rstn = 1'b1;
        tick(6);
        chk("t1_data_e6", data_o, 32'h0);
        tick(1);
        chk("t1_data_e7",  data_o, 32'h0000FFFF);
        chk("t1_event_e7", 32'(event_o), 32'h1);
        chk("t1_rise_e7",  32'(rise_o), 32'h0000FFFF);
        chk("t1_busy_e7",  32'(busy_o), 32'h0);
        read_pulse();
        chk("t1_event_rd", 32'(event_o), 32'h0);
        chk("t1_rise_rd",  32'(rise_o), 32'h0);
        chk("t1_data_rd",  data_o, 32'h0000FFFF);

        // 2. Clean change 0 -> 5.
        do_reset(16'h0000);
        sw_i = 16'h0005;
        tick(2);
        chk("t2_busy_e2", 32'(busy_o), 32'h0);
        tick(1);
        chk("t2_busy_e3", 32'(busy_o), 32'h1);
        tick(3);
        chk("t2_busy_e6", 32'(busy_o), 32'h1);
        chk("t2_data_e6", data_o, 32'h0);
        tick(1);
        chk("t2_data_e7",  data_o, 32'h5);
        chk("t2_busy_e7",  32'(busy_o), 32'h0);
        chk("t2_event_e7", 32'(event_o), 32'h1);
        chk("t2_rise_e7",  32'(rise_o), 32'h5);

        // 3. Bit0 bounces every two clocks, final 1 first sampled at edge 9.
        do_reset(16'h0000);
        for (int i = 0; i < 10; i++) begin
            sw_i = ((i % 4) < 2) ? 16'h0001 : 16'h0000;
            tick(1);
        end
        tick(4);
        chk("t3_data_e14",  data_o, 32'h0);
        chk("t3_event_e14", 32'(event_o), 32'h0);
        tick(1);
        chk("t3_data_e15",  data_o, 32'h1);
        chk("t3_event_e15", 32'(event_o), 32'h1);
        chk("t3_rise_e15",  32'(rise_o), 32'h1);

        // 4. Three-clock glitch on bit3 never commits.
        do_reset(16'h0000);
        sw_i = 16'h0008;
        tick(3);
        chk("t4_busy_e3", 32'(busy_o), 32'h1);
        sw_i = 16'h0000;
        tick(3);
        chk("t4_busy_e6", 32'(busy_o), 32'h0);
        tick(4);
        chk("t4_data",  data_o, 32'h0);
        chk("t4_event", 32'(event_o), 32'h0);

        // 5. Read clears the flags but not the data.
        sw_i = 16'h0004;
        tick(7);
        chk("t5_data",  data_o, 32'h4);
        chk("t5_event", 32'(event_o), 32'h1);
        chk("t5_rise",  32'(rise_o), 32'h4);
        read_pulse();
        chk("t5_event_rd", 32'(event_o), 32'h0);
        chk("t5_rise_rd",  32'(rise_o), 32'h0);
        chk("t5_data_rd",  data_o, 32'h4);

        // 6. Read strobe on the commit edge of 4 -> 6, with old flags pending.
        sw_i = 16'h0000;
        tick(7);
        chk("t6_data_zero", data_o, 32'h0);
        sw_i = 16'h0004;
        tick(7);
        chk("t6_data_four", data_o, 32'h4);
        chk("t6_rise_four", 32'(rise_o), 32'h4);
        sw_i = 16'h0006;
        tick(6);
        chk("t6_data_pre", data_o, 32'h4);
        read_pulse();
        chk("t6_data_post",  data_o, 32'h6);
        chk("t6_event_post", 32'(event_o), 32'h1);
        chk("t6_rise_post",  32'(rise_o), 32'h2);
        tick(1);
        chk("t6_event_hold", 32'(event_o), 32'h1);
        chk("t6_rise_hold",  32'(rise_o), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
